// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Owns the CPU reset line. Merges button, qualified DTR and
//               watchdog reset sources, stretches each reset to a minimum
//               width, holds reset while DTR stays high, and records the
//               cause and a saturating count of resets for readback.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
  parameter int DTR_MIN_CYCLES = 5000000,
  parameter int RST_CYCLES     = 16,
  parameter int WDT_CYCLES     = 25000000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_btn_stb,
  input  logic       i_dtr,
  input  logic       i_wdt_en,
  input  logic       i_wdt_kick,
  output logic       o_cpu_rst,
  output logic [1:0] o_rst_cause,
  output logic [7:0] o_rst_count,
  output logic       o_running
);

  // Counter widths sized to hold their terminal values
  localparam int DTR_W = $clog2(DTR_MIN_CYCLES + 1);
  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);

  localparam logic [DTR_W-1:0] C_DTR_MAX    = DTR_W'(DTR_MIN_CYCLES);
  localparam logic [RST_W-1:0] C_WIDTH_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [WDT_W-1:0] C_WDT_LAST   = WDT_W'(WDT_CYCLES - 1);

  localparam logic [1:0] C_CAUSE_POR = 2'd0;
  localparam logic [1:0] C_CAUSE_BTN = 2'd1;
  localparam logic [1:0] C_CAUSE_DTR = 2'd2;
  localparam logic [1:0] C_CAUSE_WDT = 2'd3;

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_HOLD   = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t           r_state;
  logic [RST_W-1:0] r_width_cnt;
  logic [DTR_W-1:0] r_dtr_cnt;
  logic [WDT_W-1:0] r_wdt_cnt;

  logic       w_dtr_trig;
  logic       w_wdt_expire;
  logic       w_run_trig;
  logic [1:0] w_cause;
  logic [7:0] w_count_next;

  // Trigger qualification and priority encoding (BTN > DTR > WDT)
  always_comb begin
    w_dtr_trig   = (r_dtr_cnt == C_DTR_MAX);
    w_wdt_expire = i_wdt_en && !i_wdt_kick && (r_wdt_cnt == C_WDT_LAST);
    w_run_trig   = (r_state == ST_RUN) && (i_btn_stb || w_dtr_trig || w_wdt_expire);
    if (i_btn_stb) begin
      w_cause = C_CAUSE_BTN;
    end else if (w_dtr_trig) begin
      w_cause = C_CAUSE_DTR;
    end else begin
      w_cause = C_CAUSE_WDT;
    end
    // Reset count saturates rather than wrapping
    w_count_next = (o_rst_count == 8'hFF) ? o_rst_count : (o_rst_count + 8'd1);
  end

  // DTR hold-time qualifier: runs in every state, clears whenever DTR drops
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dtr_cnt <= '0;
    end else if (!i_dtr) begin
      r_dtr_cnt <= '0;
    end else if (r_dtr_cnt != C_DTR_MAX) begin
      r_dtr_cnt <= r_dtr_cnt + DTR_W'(1);
    end
  end

  // Watchdog counter: only advances in RUN while enabled and not kicked
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wdt_cnt <= '0;
    end else if ((r_state != ST_RUN) || w_run_trig || !i_wdt_en || i_wdt_kick) begin
      r_wdt_cnt <= '0;
    end else begin
      r_wdt_cnt <= r_wdt_cnt + WDT_W'(1);
    end
  end

  // Sequencer FSM with registered reset, status and width counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_ASSERT;
      r_width_cnt <= '0;
      o_cpu_rst   <= 1'b1;
      o_rst_cause <= C_CAUSE_POR;
      o_rst_count <= 8'd0;
      o_running   <= 1'b0;
    end else begin
      case (r_state)
        ST_ASSERT: begin
          // Triggers are ignored here so the pulse width is never restarted
          o_cpu_rst <= 1'b1;
          o_running <= 1'b0;
          if (r_width_cnt == C_WIDTH_LAST) begin
            r_state     <= ST_HOLD;
            r_width_cnt <= '0;
          end else begin
            r_width_cnt <= r_width_cnt + RST_W'(1);
          end
        end
        ST_HOLD: begin
          if (i_btn_stb) begin
            r_state     <= ST_ASSERT;
            r_width_cnt <= '0;
            o_rst_cause <= C_CAUSE_BTN;
            o_rst_count <= w_count_next;
          end else if (!i_dtr) begin
            r_state   <= ST_RUN;
            o_cpu_rst <= 1'b0;
            o_running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_run_trig) begin
            r_state     <= ST_ASSERT;
            r_width_cnt <= '0;
            o_cpu_rst   <= 1'b1;
            o_running   <= 1'b0;
            o_rst_cause <= w_cause;
            o_rst_count <= w_count_next;
          end
        end
        default: begin
          r_state     <= ST_ASSERT;
          r_width_cnt <= '0;
          o_cpu_rst   <= 1'b1;
          o_running   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reset_sequencer
// Description : Directed self-checking bench for reset_sequencer with small
//               parameters (DTR 8, width 4, watchdog 20).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

  logic       clk;
  logic       rst_n;
  logic       btn_stb;
  logic       dtr;
  logic       wdt_en;
  logic       wdt_kick;
  logic       cpu_rst;
  logic [1:0] rst_cause;
  logic [7:0] rst_count;
  logic       running;

  int checks;
  int failures;
  int exp_count;

  reset_sequencer #(
    .DTR_MIN_CYCLES(8),
    .RST_CYCLES    (4),
    .WDT_CYCLES    (20)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_btn_stb  (btn_stb),
    .i_dtr      (dtr),
    .i_wdt_en   (wdt_en),
    .i_wdt_kick (wdt_kick),
    .o_cpu_rst  (cpu_rst),
    .o_rst_cause(rst_cause),
    .o_rst_count(rst_count),
    .o_running  (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle 1 ns past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count cycles o_cpu_rst stays high; optionally pulse the button on cycle pulse_at
  task automatic run_high(input int pulse_at, output int n);
    n = 0;
    while (cpu_rst && n < 60) begin
      n++;
      if (n == pulse_at) btn_stb = 1'b1;
      tick();
      btn_stb = 1'b0;
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; btn_stb = 1'b0; dtr = 1'b0; wdt_en = 1'b0; wdt_kick = 1'b0;
    tick(); tick();
    checks++;
    if (cpu_rst !== 1'b1 || rst_cause !== 2'd0 || rst_count !== 8'd0 || running !== 1'b0) begin
      failures++;
      $display("FAIL por_values: got rst=%b cause=%0d count=%0d run=%b, need 1/0/0/0",
               cpu_rst, rst_cause, rst_count, running);
    end
    rst_n = 1'b1;
    run_high(0, n);
    checks++;
    if (n !== 5) begin
      failures++; $display("FAIL por_width: got %0d cycles, need 5", n);
    end
    checks++;
    if (running !== 1'b1 || rst_cause !== 2'd0 || rst_count !== 8'd0) begin
      failures++;
      $display("FAIL por_run: got run=%b cause=%0d count=%0d, need 1/0/0", running, rst_cause, rst_count);
    end
    exp_count = 0;
  endtask

  task automatic test_button();
    int n;
    btn_stb = 1'b1; tick(); btn_stb = 1'b0;
    exp_count++;
    checks++;
    if (cpu_rst !== 1'b1 || running !== 1'b0 || rst_cause !== 2'd1 || rst_count !== 8'(exp_count)) begin
      failures++;
      $display("FAIL btn_latency: got rst=%b run=%b cause=%0d count=%0d, need 1/0/1/%0d",
               cpu_rst, running, rst_cause, rst_count, exp_count);
    end
    run_high(0, n);
    checks++;
    if (n !== 5) begin
      failures++; $display("FAIL btn_width: got %0d, need 5", n);
    end
    // Second press with a repeat strobe landing in ASSERT
    btn_stb = 1'b1; tick(); btn_stb = 1'b0;
    exp_count++;
    run_high(2, n);
    checks++;
    if (n !== 5 || rst_count !== 8'(exp_count) || rst_cause !== 2'd1) begin
      failures++;
      $display("FAIL btn_in_assert: got width=%0d count=%0d cause=%0d, need 5/%0d/1",
               n, rst_count, rst_cause, exp_count);
    end
  endtask

  task automatic test_dtr();
    int n;
    logic seen;
    seen = 1'b0;
    dtr = 1'b1;
    for (int i = 0; i < 7; i++) begin tick(); if (cpu_rst) seen = 1'b1; end
    dtr = 1'b0;
    for (int i = 0; i < 12; i++) begin tick(); if (cpu_rst) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0 || rst_count !== 8'(exp_count)) begin
      failures++;
      $display("FAIL dtr_glitch: got reset_seen=%b count=%0d, need 0/%0d", seen, rst_count, exp_count);
    end
    dtr = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (cpu_rst !== 1'b0) begin
      failures++; $display("FAIL dtr_early: got rst=%b after 8 high, need 0", cpu_rst);
    end
    tick();
    exp_count++;
    checks++;
    if (cpu_rst !== 1'b1 || rst_cause !== 2'd2 || rst_count !== 8'(exp_count)) begin
      failures++;
      $display("FAIL dtr_trigger: got rst=%b cause=%0d count=%0d, need 1/2/%0d",
               cpu_rst, rst_cause, rst_count, exp_count);
    end
    seen = 1'b0;
    for (int i = 0; i < 21; i++) begin tick(); if (!cpu_rst) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL dtr_hold: got a low cycle while DTR held, need none");
    end
    dtr = 1'b0;
    tick();
    checks++;
    if (cpu_rst !== 1'b0 || running !== 1'b1) begin
      failures++; $display("FAIL dtr_release: got rst=%b run=%b, need 0/1", cpu_rst, running);
    end
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (cpu_rst !== 1'b0 || rst_count !== 8'(exp_count)) begin
      failures++;
      $display("FAIL dtr_once: got rst=%b count=%0d, need 0/%0d", cpu_rst, rst_count, exp_count);
    end
    n = 0;
  endtask

  task automatic test_watchdog();
    int n;
    logic seen;
    wdt_en = 1'b1;
    btn_stb = 1'b1; tick(); btn_stb = 1'b0;
    exp_count++;
    run_high(0, n);
    n = 0;
    while (!cpu_rst && n < 60) begin tick(); n++; end
    exp_count++;
    checks++;
    if (n !== 20 || rst_cause !== 2'd3 || rst_count !== 8'(exp_count)) begin
      failures++;
      $display("FAIL wdt_expire: got %0d cycles cause=%0d count=%0d, need 20/3/%0d",
               n, rst_cause, rst_count, exp_count);
    end
    run_high(0, n);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      wdt_kick = (i % 15 == 14);
      tick();
      if (cpu_rst) seen = 1'b1;
    end
    wdt_kick = 1'b0;
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL wdt_kicked: got a reset with regular kicks, need none");
    end
    // Align a kick exactly onto the expiry cycle
    wdt_kick = 1'b1; tick(); wdt_kick = 1'b0;
    for (int i = 0; i < 19; i++) begin tick(); if (cpu_rst) seen = 1'b1; end
    wdt_kick = 1'b1; tick(); wdt_kick = 1'b0;
    if (cpu_rst) seen = 1'b1;
    for (int i = 0; i < 5; i++) begin tick(); if (cpu_rst) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0 || rst_count !== 8'(exp_count)) begin
      failures++;
      $display("FAIL wdt_kick_expiry: got reset_seen=%b count=%0d, need 0/%0d", seen, rst_count, exp_count);
    end
  endtask

  task automatic test_simultaneous();
    int n;
    wdt_kick = 1'b1; tick(); wdt_kick = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    dtr = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (cpu_rst !== 1'b0) begin
      failures++; $display("FAIL sim_setup: got rst=%b before coincident cycle, need 0", cpu_rst);
    end
    btn_stb = 1'b1; tick(); btn_stb = 1'b0;
    exp_count++;
    checks++;
    if (cpu_rst !== 1'b1 || rst_cause !== 2'd1 || rst_count !== 8'(exp_count)) begin
      failures++;
      $display("FAIL sim_priority: got rst=%b cause=%0d count=%0d, need 1/1/%0d",
               cpu_rst, rst_cause, rst_count, exp_count);
    end
    for (int i = 0; i < 6; i++) tick();
    dtr = 1'b0; wdt_en = 1'b0;
    run_high(0, n);
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (running !== 1'b1 || rst_count !== 8'(exp_count) || rst_cause !== 2'd1) begin
      failures++;
      $display("FAIL sim_single: got run=%b count=%0d cause=%0d, need 1/%0d/1",
               running, rst_count, rst_cause, exp_count);
    end
  endtask

  task automatic test_async_and_saturation();
    int n;
    btn_stb = 1'b1; tick(); btn_stb = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #2;
    checks++;
    if (cpu_rst !== 1'b1 || rst_cause !== 2'd0 || rst_count !== 8'd0 || running !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got rst=%b cause=%0d count=%0d run=%b, need 1/0/0/0",
               cpu_rst, rst_cause, rst_count, running);
    end
    tick();
    rst_n = 1'b1;
    run_high(0, n);
    checks++;
    if (n !== 5 || running !== 1'b1) begin
      failures++; $display("FAIL async_restart: got width=%0d run=%b, need 5/1", n, running);
    end
    for (int i = 1; i <= 300; i++) begin
      btn_stb = 1'b1; tick(); btn_stb = 1'b0;
      if (i == 255) begin
        checks++;
        if (rst_count !== 8'd255) begin
          failures++; $display("FAIL count_255: got %0d, need 255", rst_count);
        end
      end
      run_high(0, n);
    end
    checks++;
    if (rst_count !== 8'd255 || rst_cause !== 2'd1) begin
      failures++; $display("FAIL count_sat: got count=%0d cause=%0d, need 255/1", rst_count, rst_cause);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_count = 0;
    rst_n = 1'b0; btn_stb = 1'b0; dtr = 1'b0; wdt_en = 1'b0; wdt_kick = 1'b0;
    test_reset();
    test_button();
    test_dtr();
    test_watchdog();
    test_simultaneous();
    test_async_and_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
